// File: rtl/mem_stage.sv
// Memory-access stage: turns EX results into data-memory req/ack transactions,
// aligns byte lanes, extends loads and hands one registered result to write-back.
module mem_stage #(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_ex,
    input  logic        mem_read_ex,
    input  logic        mem_write_ex,
    input  logic [2:0]  funct3_ex,
    input  logic [31:0] alu_result_ex,
    input  logic [31:0] store_data_ex,
    input  logic [4:0]  rd_ex,
    input  logic        reg_write_ex,
    output logic        stall_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        valid_mem,
    output logic [31:0] result_mem,
    output logic [4:0]  rd_mem,
    output logic        reg_write_mem,
    output logic        exc_mem,
    output logic        bus_err_mem
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       lo_q;
    logic [4:0]       rd_q;
    logic             rw_q;

    logic is_mem, accept, exc_ex, start_mem, ack_hit, timeout;
    logic bad_ld, bad_st, mis_h, mis_w;

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   lane_be = 4'b0001 << lo;
            2'b01:   lane_be = 4'b0011 << {lo[1], 1'b0};
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   lane_wdata = {4{d[7:0]}};
            2'b01:   lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lo, 3'b000} +: 8];
        h = lo[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = d;
        endcase
    endfunction

    // Illegal encodings and misalignment are decided at accept so they never reach the bus.
    assign is_mem    = mem_read_ex | mem_write_ex;
    assign accept    = (state == IDLE) & valid_ex;
    assign bad_ld    = mem_read_ex & ((funct3_ex == 3'b011) | (funct3_ex[2:1] == 2'b11));
    assign bad_st    = mem_write_ex & (funct3_ex[2] | (funct3_ex[1:0] == 2'b11));
    assign mis_h     = is_mem & (funct3_ex[1:0] == 2'b01) & alu_result_ex[0];
    assign mis_w     = is_mem & (funct3_ex[1:0] == 2'b10) & (alu_result_ex[1:0] != 2'b00);
    assign exc_ex    = (mem_read_ex & mem_write_ex) | bad_ld | bad_st | mis_h | mis_w;
    assign start_mem = accept & is_mem & ~exc_ex;
    assign ack_hit   = (state == BUSY) & dmem_ack;
    // Abort on the cycle the count would reach ACK_TIMEOUT; a same-cycle ack takes priority.
    assign timeout   = (state == BUSY) & ~dmem_ack & (ACK_TIMEOUT != 0) &
                       (cnt == CNT_W'(ACK_TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mem) state_nxt = BUSY;
            BUSY:    if (ack_hit || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_mem = (state == BUSY);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt           <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            f3_q          <= '0;
            lo_q          <= '0;
            rd_q          <= '0;
            rw_q          <= 1'b0;
            valid_mem     <= 1'b0;
            result_mem    <= '0;
            rd_mem        <= '0;
            reg_write_mem <= 1'b0;
            exc_mem       <= 1'b0;
            bus_err_mem   <= 1'b0;
        end else begin
            valid_mem   <= 1'b0;
            exc_mem     <= 1'b0;
            bus_err_mem <= 1'b0;

            if (accept) begin
                if (!is_mem) begin
                    valid_mem     <= 1'b1;
                    result_mem    <= alu_result_ex;
                    rd_mem        <= rd_ex;
                    reg_write_mem <= reg_write_ex;
                end else if (exc_ex) begin
                    valid_mem     <= 1'b1;
                    exc_mem       <= 1'b1;
                    result_mem    <= alu_result_ex;
                    rd_mem        <= rd_ex;
                    reg_write_mem <= 1'b0;
                end else begin
                    cnt        <= '0;
                    dmem_req   <= 1'b1;
                    dmem_we    <= mem_write_ex;
                    dmem_addr  <= {alu_result_ex[31:2], 2'b00};
                    dmem_wdata <= lane_wdata(funct3_ex, store_data_ex);
                    dmem_be    <= lane_be(funct3_ex, alu_result_ex[1:0]);
                    f3_q       <= funct3_ex;
                    lo_q       <= alu_result_ex[1:0];
                    rd_q       <= rd_ex;
                    rw_q       <= reg_write_ex;
                end
            end

            if (state == BUSY) begin
                if (dmem_ack) begin
                    dmem_req  <= 1'b0;
                    valid_mem <= 1'b1;
                    rd_mem    <= rd_q;
                    if (dmem_we) begin
                        result_mem    <= '0;
                        reg_write_mem <= 1'b0;
                    end else begin
                        result_mem    <= load_ext(f3_q, lo_q, dmem_rdata);
                        reg_write_mem <= rw_q;
                    end
                end else if (timeout) begin
                    dmem_req      <= 1'b0;
                    valid_mem     <= 1'b1;
                    bus_err_mem   <= 1'b1;
                    result_mem    <= {dmem_addr[31:2], lo_q};
                    rd_mem        <= rd_q;
                    reg_write_mem <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: non-memory ops, loads/stores, exceptions,
// ack timeout and asynchronous reset mid-transaction.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid_ex = 1'b0, mem_read_ex = 1'b0, mem_write_ex = 1'b0;
    logic [2:0]  funct3_ex = '0;
    logic [31:0] alu_result_ex = '0, store_data_ex = '0;
    logic [4:0]  rd_ex = '0;
    logic        reg_write_ex = 1'b0;
    logic        stall_mem, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        valid_mem;
    logic [31:0] result_mem;
    logic [4:0]  rd_mem;
    logic        reg_write_mem, exc_mem, bus_err_mem;

    int checks = 0;
    int errors = 0;
    int n;

    mem_stage #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .valid_ex(valid_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .funct3_ex(funct3_ex), .alu_result_ex(alu_result_ex), .store_data_ex(store_data_ex),
        .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
        .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .valid_mem(valid_mem), .result_mem(result_mem), .rd_mem(rd_mem),
        .reg_write_mem(reg_write_mem), .exc_mem(exc_mem), .bus_err_mem(bus_err_mem)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic rw);
        valid_ex      = 1'b1;
        mem_read_ex   = rd_op;
        mem_write_ex  = wr_op;
        funct3_ex     = f3;
        alu_result_ex = addr;
        store_data_ex = sdata;
        rd_ex         = rd;
        reg_write_ex  = rw;
    endtask

    // Counts request cycles, acking on cycle ack_cycle (0 = never); bounded at 16 cycles.
    task automatic run_busy(input int ack_cycle, input logic [31:0] rdata, output int cnt);
        cnt = 0;
        valid_ex = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (!dmem_req) break;
            cnt++;
            check("stall_busy", {31'd0, stall_mem}, 32'd1);
            if (k == ack_cycle) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
            dmem_ack = 1'b0;
        end
    endtask

    initial begin
        #1;
        check("rst_stall", {31'd0, stall_mem}, 32'd0);
        check("rst_req",   {31'd0, dmem_req},  32'd0);
        check("rst_valid", {31'd0, valid_mem}, 32'd0);
        check("rst_result", result_mem, 32'd0);
        tick(); tick();
        @(negedge clk) rstn = 1'b1;
        tick();

        // Non-memory ops, back to back
        issue(0, 0, 3'b000, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
        tick();
        check("alu_valid",  {31'd0, valid_mem}, 32'd1);
        check("alu_result", result_mem, 32'h0000_1234);
        check("alu_rd",     {27'd0, rd_mem}, 32'd5);
        check("alu_rw",     {31'd0, reg_write_mem}, 32'd1);
        check("alu_stall",  {31'd0, stall_mem}, 32'd0);
        issue(0, 0, 3'b000, 32'hCAFE_0001, 32'd0, 5'd9, 1'b0);
        tick();
        check("b2b_valid",  {31'd0, valid_mem}, 32'd1);
        check("b2b_result", result_mem, 32'hCAFE_0001);
        check("b2b_rd",     {27'd0, rd_mem}, 32'd9);
        check("b2b_rw",     {31'd0, reg_write_mem}, 32'd0);
        valid_ex = 1'b0;
        tick();
        check("idle_valid", {31'd0, valid_mem}, 32'd0);
        check("hold_result", result_mem, 32'hCAFE_0001);

        // Stray ack in IDLE is ignored
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("stray_ack_valid", {31'd0, valid_mem}, 32'd0);

        // LB at 0x103, ack in third request cycle
        issue(1, 0, 3'b000, 32'h0000_0103, 32'd0, 5'd3, 1'b1);
        tick();
        check("lb_req",  {31'd0, dmem_req}, 32'd1);
        check("lb_addr", dmem_addr, 32'h0000_0100);
        check("lb_be",   {28'd0, dmem_be}, 32'b1000);
        check("lb_we",   {31'd0, dmem_we}, 32'd0);
        run_busy(3, 32'h80FF_0000, n);
        check("lb_cycles", n, 32'd3);
        check("lb_valid",  {31'd0, valid_mem}, 32'd1);
        check("lb_result", result_mem, 32'hFFFF_FF80);
        check("lb_rw",     {31'd0, reg_write_mem}, 32'd1);
        check("lb_req_off", {31'd0, dmem_req}, 32'd0);
        check("lb_stall_off", {31'd0, stall_mem}, 32'd0);

        // LBU at same address, accepted in the completion cycle
        issue(1, 0, 3'b100, 32'h0000_0103, 32'd0, 5'd4, 1'b1);
        tick();
        run_busy(1, 32'h80FF_0000, n);
        check("lbu_result", result_mem, 32'h0000_0080);

        // LH upper half, sign-extended
        issue(1, 0, 3'b001, 32'h0000_0106, 32'd0, 5'd4, 1'b1);
        tick();
        check("lh_be", {28'd0, dmem_be}, 32'b1100);
        run_busy(1, 32'h9ABC_1234, n);
        check("lh_result", result_mem, 32'hFFFF_9ABC);

        // SH at 0x202, immediate ack
        issue(0, 1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd6, 1'b1);
        tick();
        check("sh_we",    {31'd0, dmem_we}, 32'd1);
        check("sh_be",    {28'd0, dmem_be}, 32'b1100);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check("sh_addr",  dmem_addr, 32'h0000_0200);
        run_busy(1, 32'd0, n);
        check("sh_cycles", n, 32'd1);
        check("sh_valid",  {31'd0, valid_mem}, 32'd1);
        check("sh_rw",     {31'd0, reg_write_mem}, 32'd0);
        check("sh_result", result_mem, 32'd0);

        // Misaligned LW and illegal load funct3
        issue(1, 0, 3'b010, 32'h0000_0301, 32'd0, 5'd7, 1'b1);
        tick();
        check("mis_req",    {31'd0, dmem_req}, 32'd0);
        check("mis_stall",  {31'd0, stall_mem}, 32'd0);
        check("mis_valid",  {31'd0, valid_mem}, 32'd1);
        check("mis_exc",    {31'd0, exc_mem}, 32'd1);
        check("mis_rw",     {31'd0, reg_write_mem}, 32'd0);
        check("mis_result", result_mem, 32'h0000_0301);
        issue(1, 0, 3'b011, 32'h0000_0000, 32'd0, 5'd7, 1'b1);
        tick();
        check("f3_011_exc", {31'd0, exc_mem}, 32'd1);
        check("f3_011_req", {31'd0, dmem_req}, 32'd0);
        valid_ex = 1'b0;
        tick();
        check("exc_pulse", {31'd0, exc_mem}, 32'd0);

        // Ack timeout, then ack on the last allowed cycle
        issue(1, 0, 3'b010, 32'h0000_0500, 32'd0, 5'd8, 1'b1);
        tick();
        run_busy(0, 32'd0, n);
        check("to_cycles", n, 32'd4);
        check("to_valid",  {31'd0, valid_mem}, 32'd1);
        check("to_buserr", {31'd0, bus_err_mem}, 32'd1);
        check("to_rw",     {31'd0, reg_write_mem}, 32'd0);
        tick();
        check("to_pulse",  {31'd0, bus_err_mem}, 32'd0);
        issue(1, 0, 3'b010, 32'h0000_0500, 32'd0, 5'd8, 1'b1);
        tick();
        run_busy(4, 32'h0BAD_F00D, n);
        check("ack4_cycles", n, 32'd4);
        check("ack4_valid",  {31'd0, valid_mem}, 32'd1);
        check("ack4_buserr", {31'd0, bus_err_mem}, 32'd0);
        check("ack4_result", result_mem, 32'h0BAD_F00D);

        // Reset in the middle of a transaction
        issue(1, 0, 3'b000, 32'h0000_0010, 32'd0, 5'd2, 1'b1);
        tick();
        check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        valid_ex = 1'b0;
        tick();
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_req",   {31'd0, dmem_req},  32'd0);
        check("rst_mid_stall", {31'd0, stall_mem}, 32'd0);
        check("rst_mid_valid", {31'd0, valid_mem}, 32'd0);
        @(negedge clk) rstn = 1'b1;
        tick();
        check("post_rst_valid", {31'd0, valid_mem}, 32'd0);
        issue(1, 0, 3'b010, 32'h0000_0400, 32'd0, 5'd1, 1'b1);
        tick();
        check("lw_addr", dmem_addr, 32'h0000_0400);
        check("lw_be",   {28'd0, dmem_be}, 32'b1111);
        run_busy(2, 32'h1122_3344, n);
        check("lw_cycles", n, 32'd2);
        check("lw_valid",  {31'd0, valid_mem}, 32'd1);
        check("lw_result", result_mem, 32'h1122_3344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
